// File: rtl/ysyx_25010008_lfsr.sv
// ysyx_25010008_lfsr
// Free-running Fibonacci LFSR that produces a pseudo-random, never-zero value
// every clock. The memory model uses it as a randomised access delay.
// The state shifts left and the feedback enters at the LSB. The tap set is
// chosen from WIDTH when the design is elaborated.
module ysyx_25010008_lfsr #(
   parameter int                WIDTH = 8,
   parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] dout
);

   // Maximal-length tap masks. Bit n-1 is set for polynomial term x^n.
   // A zero mask marks an unsupported width.
   function automatic logic [15:0] tap_mask(input int w);
      logic [15:0] m;
      case (w)
         32'd4:   m = 16'h000C;   // 4,3
         32'd5:   m = 16'h0014;   // 5,3
         32'd6:   m = 16'h0030;   // 6,5
         32'd7:   m = 16'h0060;   // 7,6
         32'd8:   m = 16'h00B8;   // 8,6,5,4
         32'd9:   m = 16'h0110;   // 9,5
         32'd10:  m = 16'h0240;   // 10,7
         32'd11:  m = 16'h0500;   // 11,9
         32'd12:  m = 16'h0829;   // 12,6,4,1
         32'd13:  m = 16'h100D;   // 13,4,3,1
         32'd14:  m = 16'h2015;   // 14,5,3,1
         32'd15:  m = 16'h6000;   // 15,14
         32'd16:  m = 16'hD008;   // 16,15,13,4
         default: m = 16'h0000;
      endcase
      return m;
   endfunction

   localparam logic [15:0]      TAP_MASK16 = tap_mask(WIDTH);
   localparam logic [WIDTH-1:0] TAPS       = TAP_MASK16[WIDTH-1:0];
   // An all-zero seed would lock the register at zero, so it becomes 1.
   localparam logic [WIDTH-1:0] EFF_SEED   = (SEED == {WIDTH{1'b0}}) ?
                                             {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

   if ((WIDTH < 4) || (WIDTH > 16)) begin : g_bad_width
      $error("ysyx_25010008_lfsr: WIDTH %0d unsupported (4..16)", WIDTH);
   end

   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] w_next;
   logic             w_fb;

   // Next state: shift in the feedback bit, or restart from the seed if the state is all-zero.
   always_comb begin
      w_fb   = ^(r_state & TAPS);
      w_next = EFF_SEED;
      if (r_state == {WIDTH{1'b0}}) begin
         w_next = EFF_SEED;
      end else begin
         w_next = {r_state[WIDTH-2:0], w_fb};
      end
   end

   // State register: synchronous reset to the seed, otherwise advance one step.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EFF_SEED;
      end else begin
         r_state <= w_next;
      end
   end

   assign dout = r_state;

endmodule

// File: tb/tb_ysyx_25010008_lfsr.sv
// Testbench for ysyx_25010008_lfsr.
// Three instances share one clock and reset: the default, WIDTH=4, and SEED=0.
// Expected values come from a reference model that is built from the
// polynomial tap positions.
module tb_ysyx_25010008_lfsr;

   logic       clk;
   logic       rst;
   logic [7:0] dout8;
   logic [3:0] dout4;
   logic [7:0] doutz;

   int n_checks;
   int n_fail;

   // Reference model states
   int m8;
   int m4;
   int mz;

   ysyx_25010008_lfsr u_dut (
      .clk  (clk),
      .rst  (rst),
      .dout (dout8)
   );

   ysyx_25010008_lfsr #(.WIDTH(4), .SEED(4'h1)) u_dut4 (
      .clk  (clk),
      .rst  (rst),
      .dout (dout4)
   );

   ysyx_25010008_lfsr #(.WIDTH(8), .SEED(8'h00)) u_dutz (
      .clk  (clk),
      .rst  (rst),
      .dout (doutz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One step of a Fibonacci LFSR, given its 1-based tap positions.
   // An all-zero state restarts at 1, which is the effective seed in every
   // instance here.
   function automatic int model_next(input int s, input int w);
      int taps[$];
      int fb;
      if (s == 0) return 1;
      case (w)
         4:       taps = '{4, 3};
         8:       taps = '{8, 6, 5, 4};
         default: taps = '{};
      endcase
      fb = 0;
      foreach (taps[k]) fb = fb ^ ((s >> (taps[k] - 1)) % 2);
      return ((s * 2) % (1 << w)) + fb;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, step the models with the reset seen at the edge, and compare all three instances.
   task automatic tick(input string tag);
      logic r;
      @(posedge clk);
      r = rst;
      m8 = r ? 1 : model_next(m8, 8);
      m4 = r ? 1 : model_next(m4, 4);
      mz = r ? 1 : model_next(mz, 8);
      #1;
      chk({tag, "_d8"}, {8'h00, dout8}, m8[15:0]);
      chk({tag, "_d4"}, {12'h000, dout4}, m4[15:0]);
      chk({tag, "_dz"}, {8'h00, doutz}, mz[15:0]);
   endtask

   logic [7:0] exp_seq [9];
   bit         seen8 [256];
   bit         seen4 [16];
   int         distinct8;
   int         distinct4;
   bit         found;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m8 = 0; m4 = 0; mz = 0;
      exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};

      // Hold reset for three cycles. All instances must read 1.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick("reset_hold");
         chk("reset_d8", {8'h00, dout8}, 16'h0001);
         chk("reset_seed0", {8'h00, doutz}, 16'h0001);
      end

      // Release reset and compare against the documented start of the sequence.
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         chk("seq_from_reset", {8'h00, dout8}, {8'h00, exp_seq[i]});
         if (i < 8) tick("seq_step");
      end

      // Full period: 255 distinct nonzero values, then back to 01.
      // WIDTH=4 repeats every 15 steps.
      rst = 1'b1;
      tick("period_reset");
      rst = 1'b0;
      for (int v = 0; v < 256; v++) seen8[v] = 1'b0;
      for (int v = 0; v < 16; v++) seen4[v] = 1'b0;
      distinct8 = 0;
      distinct4 = 0;
      for (int i = 0; i < 255; i++) begin
         if (!seen8[dout8]) distinct8++;
         seen8[dout8] = 1'b1;
         if (i < 15) begin
            if (!seen4[dout4]) distinct4++;
            seen4[dout4] = 1'b1;
         end
         tick("period");
         if (i == 14) chk("w4_period15", {12'h000, dout4}, 16'h0001);
      end
      chk("period_distinct", distinct8[15:0], 16'd255);
      chk("period_zero_seen", {15'h0000, seen8[0]}, 16'h0000);
      chk("period_wrap", {8'h00, dout8}, 16'h0001);
      chk("w4_distinct", distinct4[15:0], 16'd15);
      chk("w4_zero_seen", {15'h0000, seen4[0]}, 16'h0000);

      // Reset mid-sequence while dout is 0x47. The sequence must restart.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (dout8 == 8'h47) found = 1'b1;
         else tick("seek47");
      end
      chk("seek47_timeout", {15'h0000, found}, 16'h0001);
      rst = 1'b1;
      tick("mid_reset");
      chk("mid_reset_01", {8'h00, dout8}, 16'h0001);
      rst = 1'b0;
      tick("mid_after");
      chk("mid_after_02", {8'h00, dout8}, 16'h0002);
      tick("mid_after");
      chk("mid_after_04", {8'h00, dout8}, 16'h0004);

      // Lock-up guard: force the state to zero. The next edge must reload the seed.
      force u_dut.r_state = 8'h00;
      #1;
      release u_dut.r_state;
      m8 = 0;
      tick("lockup");
      chk("lockup_01", {8'h00, dout8}, 16'h0001);
      tick("lockup_next");

      // Random reset pulses against the model.
      for (int i = 0; i < 300; i++) begin
         rst = ($urandom_range(0, 15) == 0);
         tick("random");
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
